axi_dma_cfg_seq: RTL and testbench

// Hardware AXI4 configuration sequencer for the axi_dma slave register port. It holds a small

---
 rtl/axi_dma_cfg_seq_if.sv | 46 ++++
 rtl/axi_dma_cfg_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_dma_cfg_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_cfg_seq_if.sv
// AXI4 master bus between the configuration sequencer and the DMA slave register port.
// Only the single-beat subset the sequencer drives is carried.
interface axi_dma_cfg_seq_if #(
    parameter int unsigned S_ADDR_W   = 32,
    parameter int unsigned S_DATA_W   = 32,
    parameter int unsigned MST_ID_W   = 5,
    parameter int unsigned ATX_LEN_W  = 8,
    parameter int unsigned ATX_RESP_W = 2
);
    logic [MST_ID_W-1:0]   awid;
    logic [S_ADDR_W-1:0]   awaddr;
    logic [ATX_LEN_W-1:0]  awlen;
    logic                  awvalid;
    logic                  awready;
    logic [S_DATA_W-1:0]   wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [MST_ID_W-1:0]   bid;
    logic [ATX_RESP_W-1:0] bresp;
    logic                  bvalid;
    logic                  bready;
    logic [MST_ID_W-1:0]   arid;
    logic [S_ADDR_W-1:0]   araddr;
    logic [ATX_LEN_W-1:0]  arlen;
    logic                  arvalid;
    logic                  arready;
    logic [MST_ID_W-1:0]   rid;
    logic [S_DATA_W-1:0]   rdata;
    logic [ATX_RESP_W-1:0] rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        output arid, araddr, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        input  arid, araddr, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_dma_cfg_seq.sv
// Replays a small stored program of register reads/writes as single-beat AXI4 transactions,
// bounding outstanding writes and using each read as a barrier behind all prior writes.
module axi_dma_cfg_seq #(
    parameter int unsigned S_ADDR_W   = 32,
    parameter int unsigned S_DATA_W   = 32,
    parameter int unsigned MST_ID_W   = 5,
    parameter int unsigned ATX_LEN_W  = 8,
    parameter int unsigned ATX_RESP_W = 2,
    parameter int unsigned CMD_DEPTH  = 16,
    parameter int unsigned MAX_OSTD   = 4,
    parameter int unsigned BASE_ID    = 1,
    parameter bit          REPLAY_EN  = 1'b1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_rw_i,
    input  logic [S_ADDR_W-1:0] cmd_addr_i,
    input  logic [S_DATA_W-1:0] cmd_data_i,
    input  logic                cmd_clr_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [7:0]          err_cnt_o,
    output logic                rd_valid_o,
    output logic [S_DATA_W-1:0] rd_data_o,
    axi_dma_cfg_seq_if.master   m_axi
);
    localparam int unsigned IDX_W  = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned OSTD_W = $clog2(MAX_OSTD + 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StWrite, StRdBar, StRdAddr, StRdData, StDrain, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, idx_q, idx_d;
    logic [MST_ID_W-1:0]   wid_q, wid_d;
    logic [OSTD_W-1:0]     ostd_q, ostd_d;
    logic                  aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
    logic                  rd_valid_q, rd_valid_d, err_q, err_d, rdy_q;
    logic [S_DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  retire, r_err, clr_err, b_hs, b_err, b_dec, prog_load;
    logic [1:0]            err_inc;
    logic [8:0]            cnt_sum;

    logic [CMD_DEPTH-1:0]  prog_rw_q;
    logic [S_ADDR_W-1:0]   prog_addr_q [CMD_DEPTH];
    logic [S_DATA_W-1:0]   prog_data_q [CMD_DEPTH];
    logic [IDX_W-1:0]      sel;

    assign sel       = idx_q[IDX_W-1:0];
    assign prog_load = cmd_valid_i && cmd_ready_o && !cmd_clr_i;

    // Program storage needs no reset: cnt_q alone defines which entries are live.
    always_ff @(posedge aclk) begin
        if (prog_load) begin
            prog_rw_q[cnt_q[IDX_W-1:0]]   <= cmd_rw_i;
            prog_addr_q[cnt_q[IDX_W-1:0]] <= cmd_addr_i;
            prog_data_q[cnt_q[IDX_W-1:0]] <= cmd_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wid_d      = wid_q;
        aw_pend_d  = aw_pend_q;
        w_pend_d   = w_pend_q;
        ar_pend_d  = ar_pend_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        retire     = 1'b0;
        r_err      = 1'b0;
        clr_err    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_clr_i)      cnt_d = '0;
                else if (prog_load) cnt_d = cnt_q + CNT_W'(1);
                if (start_i) begin
                    clr_err = 1'b1;
                    idx_d   = '0;
                    wid_d   = MST_ID_W'(BASE_ID);
                    state_d = (cnt_q == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (idx_q == cnt_q) begin
                    state_d = StDrain;
                end else if (prog_rw_q[sel]) begin
                    state_d = StRdBar;
                end else if (ostd_q < OSTD_W'(MAX_OSTD)) begin
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                aw_pend_d = aw_pend_q && !m_axi.awready;
                w_pend_d  = w_pend_q && !m_axi.wready;
                if (!aw_pend_d && !w_pend_d) begin
                    retire  = 1'b1;
                    idx_d   = idx_q + CNT_W'(1);
                    wid_d   = wid_q + MST_ID_W'(1);
                    state_d = StFetch;
                end
            end
            StRdBar: begin
                if (ostd_q == '0) begin
                    ar_pend_d = 1'b1;
                    state_d   = StRdAddr;
                end
            end
            StRdAddr: begin
                if (m_axi.arready) begin
                    ar_pend_d = 1'b0;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (m_axi.rvalid && rdy_q && m_axi.rlast) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = m_axi.rdata;
                    r_err      = (m_axi.rresp != '0);
                    idx_d      = idx_q + CNT_W'(1);
                    state_d    = StFetch;
                end
            end
            StDrain: if (ostd_q == '0) state_d = StDone;
            StDone: begin
                idx_d   = '0;
                if (!REPLAY_EN) cnt_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A B response with nothing outstanding is flagged but never underflows the counter.
    assign b_hs    = m_axi.bvalid && rdy_q;
    assign b_err   = b_hs && ((m_axi.bresp != '0) || (ostd_q == '0));
    assign b_dec   = b_hs && (ostd_q != '0);
    assign err_inc = {1'b0, b_err} + {1'b0, r_err};
    assign cnt_sum = {1'b0, err_cnt_q} + {7'b0, err_inc};

    always_comb begin
        ostd_d = ostd_q;
        if (retire && !b_dec)      ostd_d = ostd_q + OSTD_W'(1);
        else if (!retire && b_dec) ostd_d = ostd_q - OSTD_W'(1);
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (err_inc != '0) begin
            err_d     = 1'b1;
            err_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            wid_q      <= '0;
            ostd_q     <= '0;
            aw_pend_q  <= 1'b0;
            w_pend_q   <= 1'b0;
            ar_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wid_q      <= wid_d;
            ostd_q     <= ostd_d;
            aw_pend_q  <= aw_pend_d;
            w_pend_q   <= w_pend_d;
            ar_pend_q  <= ar_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            rdy_q      <= 1'b1;
        end
    end

    assign cmd_ready_o = (state_q == StIdle) && (cnt_q != CNT_W'(CMD_DEPTH));
    assign busy_o      = (state_q != StIdle) && (state_q != StDone);
    assign done_o      = (state_q == StDone);
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;

    assign m_axi.awid    = wid_q;
    assign m_axi.awaddr  = prog_addr_q[sel];
    assign m_axi.awlen   = '0;
    assign m_axi.awvalid = aw_pend_q;
    assign m_axi.wdata   = prog_data_q[sel];
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = w_pend_q;
    assign m_axi.bready  = rdy_q;
    assign m_axi.arid    = '0;
    assign m_axi.araddr  = prog_addr_q[sel];
    assign m_axi.arlen   = '0;
    assign m_axi.arvalid = ar_pend_q;
    assign m_axi.rready  = rdy_q;

    logic unused_ids;
    assign unused_ids = ^{m_axi.bid, m_axi.rid};
endmodule

// File: tb/tb_axi_dma_cfg_seq.sv
// Scoreboard bench for axi_dma_cfg_seq: directed programs queue expected AXI beats, read-back
// data and run results; a negedge slave/monitor process answers the bus and pops/compares.
module tb_axi_dma_cfg_seq;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid_i, cmd_ready_o, cmd_rw_i, cmd_clr_i, start_i;
    logic [31:0] cmd_addr_i, cmd_data_i, rd_data_o;
    logic        busy_o, done_o, err_o, rd_valid_o;
    logic [7:0]  err_cnt_o;

    always #5 aclk = ~aclk;

    axi_dma_cfg_seq_if #(.S_ADDR_W(32), .S_DATA_W(32), .MST_ID_W(5), .ATX_LEN_W(8),
                         .ATX_RESP_W(2)) bus ();

    axi_dma_cfg_seq #(.CMD_DEPTH(16), .MAX_OSTD(4), .BASE_ID(1), .REPLAY_EN(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_rw_i(cmd_rw_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .cmd_clr_i(cmd_clr_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .m_axi(bus)
    );

    typedef struct { int due; logic [4:0] id; logic [1:0] resp; } b_ent_t;

    logic [36:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$], exp_ar_q[$], exp_rd_q[$];
    logic [8:0]  exp_done_q[$];
    b_ent_t      b_pend_q[$];
    logic [4:0]  aw_id_q[$];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, aw_cnt = 0, b_cnt = 0, done_cnt = 0, w_pend = 0, run_wr = 0, err_at = 0;
    int r_due = 0;
    bit r_pend = 1'b0, b_hold = 1'b0, aw_rdy = 1'b1, w_rdy = 1'b1;
    logic [31:0] r_data_v = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [63:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got unexpected 0x%0h, expected nothing", name, act);
    endtask

    // Slave responder and output monitor; DUT outputs are stable at the falling edge.
    initial begin
        b_ent_t e;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = '0;
        bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
        forever begin
            @(negedge aclk);
            cyc++;
            bus.awready = aw_rdy;
            bus.wready  = w_rdy;
            bus.arready = 1'b1;
            if (!aresetn) begin
                bus.bvalid = 1'b0;
                bus.rvalid = 1'b0;
                b_pend_q.delete();
                aw_id_q.delete();
                w_pend = 0;
                r_pend = 1'b0;
            end else begin
                if (bus.bvalid && bus.bready) begin bus.bvalid = 1'b0; b_cnt++; end
                if (bus.rvalid && bus.rready) bus.rvalid = 1'b0;
                if (bus.awvalid && bus.awready) begin
                    if (exp_aw_q.size() == 0) extra("aw_beat", {bus.awid, bus.awaddr});
                    else check("aw_id_addr", {bus.awid, bus.awaddr}, exp_aw_q.pop_front());
                    check("aw_len", bus.awlen, 0);
                    aw_cnt++;
                    aw_id_q.push_back(bus.awid);
                end
                if (bus.wvalid && bus.wready) begin
                    if (exp_w_q.size() == 0) extra("w_beat", bus.wdata);
                    else check("w_data_last", {bus.wlast, bus.wdata}, {1'b1, exp_w_q.pop_front()});
                    w_pend++;
                end
                if (bus.arvalid && bus.arready) begin
                    if (exp_ar_q.size() == 0) extra("ar_beat", bus.araddr);
                    else check("ar_id_addr", {bus.arid, bus.araddr}, {5'd0, exp_ar_q.pop_front()});
                    check("ar_barrier_b_done", b_cnt, aw_cnt);
                    r_pend = 1'b1;
                    r_due  = cyc + 2;
                end
                if (rd_valid_o) begin
                    if (exp_rd_q.size() == 0) extra("rd_valid", rd_data_o);
                    else check("rd_data", rd_data_o, exp_rd_q.pop_front());
                end
                if (done_o) begin
                    if (exp_done_q.size() == 0) extra("done_pulse", {err_o, err_cnt_o});
                    else check("done_err_cnt", {err_o, err_cnt_o}, exp_done_q.pop_front());
                    check("done_busy_low", busy_o, 0);
                    done_cnt++;
                end
                while (aw_id_q.size() > 0 && w_pend > 0) begin
                    w_pend--;
                    run_wr++;
                    e.due  = cyc + 2;
                    e.id   = aw_id_q.pop_front();
                    e.resp = (run_wr == err_at) ? 2'b10 : 2'b00;
                    b_pend_q.push_back(e);
                end
                if (!bus.bvalid && !b_hold && b_pend_q.size() > 0 && b_pend_q[0].due <= cyc) begin
                    e = b_pend_q.pop_front();
                    bus.bvalid = 1'b1; bus.bid = e.id; bus.bresp = e.resp;
                end
                if (r_pend && cyc >= r_due && !bus.rvalid) begin
                    bus.rvalid = 1'b1; bus.rdata = r_data_v; bus.rresp = 2'b00;
                    bus.rlast = 1'b1; bus.rid = '0; r_pend = 1'b0;
                end
            end
        end
    end

    task automatic load(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        check("cmd_ready_load", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_rw_i = rw; cmd_addr_i = addr; cmd_data_i = data;
        @(negedge aclk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic load_wr(input logic [31:0] addr, input logic [31:0] data, input int id);
        load(1'b0, addr, data);
        exp_aw_q.push_back({id[4:0], addr});
        exp_w_q.push_back(data);
    endtask

    task automatic clr();
        cmd_clr_i = 1'b1;
        @(negedge aclk);
        cmd_clr_i = 1'b0;
    endtask

    task automatic run(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        run_wr = 0;
        start_i = 1'b1;
        @(negedge aclk);
        start_i = 1'b0;
        check({name, "_err_clr"}, {err_o, err_cnt_o}, 0);
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge aclk);
        repeat (3) @(negedge aclk);
        check({name, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int a0;
        logic [31:0] addr;
        cmd_valid_i = 1'b0; cmd_rw_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0;
        cmd_clr_i = 1'b0; start_i = 1'b0;
        #12;
        check("rst_outs", {cmd_ready_o, busy_o, done_o, err_o, err_cnt_o, rd_valid_o}, 13'h1000);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_valids_bready", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready}, 0);
        #10 aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_ready", {bus.bready, bus.rready}, 2'b11);

        // T1: 15 writes, ids 1..15
        clr();
        for (int i = 0; i < 15; i++) begin
            addr = (i < 14) ? 32'h8000_0000 + i : 32'h8000_1000;
            load_wr(addr, 32'hA000_0000 + i, i + 1);
        end
        exp_done_q.push_back(9'h000);
        a0 = aw_cnt;
        run("t1", 600);
        check("t1_aw_count", aw_cnt - a0, 15);

        // T2: B withheld caps issue at 4; full program drops cmd_ready
        clr();
        for (int i = 0; i < 16; i++) load_wr(32'h8000_0100 + 4 * i, 32'hB000_0000 + i, i + 1);
        check("t2_full_not_ready", cmd_ready_o, 0);
        exp_done_q.push_back(9'h000);
        a0 = aw_cnt;
        b_hold = 1'b1;
        start_i = 1'b1;
        @(negedge aclk);
        start_i = 1'b0;
        repeat (40) @(negedge aclk);
        check("t2_aw_stalled_at_4", aw_cnt - a0, 4);
        check("t2_busy_stalled", busy_o, 1);
        b_hold = 1'b0;
        for (int i = 0; i < 600 && done_o == 1'b0; i++) @(negedge aclk);
        repeat (3) @(negedge aclk);
        check("t2_aw_total", aw_cnt - a0, 16);

        // T3: read waits for both writes, read-back data returned
        clr();
        load_wr(32'h8000_0200, 32'h0000_0011, 1);
        load_wr(32'h8000_0204, 32'h0000_0022, 2);
        load(1'b1, 32'h8000_2001, 32'h0);
        exp_ar_q.push_back(32'h8000_2001);
        exp_rd_q.push_back(32'h0000_0002);
        r_data_v = 32'h0000_0002;
        exp_done_q.push_back(9'h000);
        run("t3", 200);
        check("t3_rd_data_held", rd_data_o, 32'h2);

        // T4: SLVERR on 3rd write; next start clears it
        clr();
        for (int i = 0; i < 5; i++) load_wr(32'h8000_0300 + 4 * i, 32'hC000_0000 + i, i + 1);
        err_at = 3;
        exp_done_q.push_back(9'h101);
        run("t4a", 300);
        err_at = 0;
        check("t4_err_sticky", {err_o, err_cnt_o}, 9'h101);
        for (int i = 0; i < 5; i++) begin
            exp_aw_q.push_back({5'(i + 1), 32'h8000_0300 + 4 * i});
            exp_w_q.push_back(32'hC000_0000 + i);
        end
        exp_done_q.push_back(9'h000);
        run("t4b", 300);

        // T5: replay twice, then an emptied program finishes at once
        clr();
        for (int i = 0; i < 3; i++) load_wr(32'h8000_0400 + 4 * i, 32'hD000_0000 + i, i + 1);
        for (int i = 0; i < 3; i++) begin
            exp_aw_q.push_back({5'(i + 1), 32'h8000_0400 + 4 * i});
            exp_w_q.push_back(32'hD000_0000 + i);
        end
        exp_done_q.push_back(9'h000);
        exp_done_q.push_back(9'h000);
        a0 = aw_cnt;
        run("t5a", 200);
        run("t5b", 200);
        check("t5_aw_replayed", aw_cnt - a0, 6);
        clr();
        exp_done_q.push_back(9'h000);
        run("t5_empty", 4);
        check("t5_empty_no_aw", aw_cnt - a0, 6);

        // T6: reset while awvalid held
        clr();
        for (int i = 0; i < 8; i++) load(1'b0, 32'h8000_0500 + 4 * i, 32'hE000_0000 + i);
        aw_rdy = 1'b0;
        w_rdy = 1'b0;
        start_i = 1'b1;
        @(negedge aclk);
        start_i = 1'b0;
        for (int i = 0; i < 10 && bus.awvalid == 1'b0; i++) @(negedge aclk);
        check("t6_awvalid_up", {bus.awvalid, bus.wvalid, busy_o}, 3'b111);
        a0 = done_cnt;
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready}, 0);
        check("t6_rst_status", {busy_o, done_o, cmd_ready_o}, 3'b001);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        aw_rdy = 1'b1;
        w_rdy = 1'b1;
        repeat (3) @(negedge aclk);
        check("t6_after_rst", {busy_o, cmd_ready_o, bus.bready}, 3'b011);
        check("t6_no_done", done_cnt - a0, 0);
        a0 = aw_cnt;
        exp_done_q.push_back(9'h000);
        run("t6_cleared", 4);
        check("t6_prog_cleared", aw_cnt - a0, 0);

        repeat (5) @(negedge aclk);
        check("left_aw", exp_aw_q.size(), 0);
        check("left_w", exp_w_q.size(), 0);
        check("left_ar_rd", exp_ar_q.size() + exp_rd_q.size(), 0);
        check("left_done", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
